btc_miner_wb_regs: RTL and testbench

Wishbone responder that terminates the register bus driven by the miner's UART-to-Wishbone bridge. It holds the job configuration (midstate, header tail, nonce range) and issues start/abort pulses to the hash core. It also buffers found nonces in a small FIFO for the host to read back. It sits between the bridge's Wishbone master port and the hashing pipeline.

---
 rtl/btc_miner_wb_regs_if.sv | 32 +++
 rtl/btc_miner_wb_regs.sv | 227 ++++++++++++++++++++++
 tb/tb_btc_miner_wb_regs.sv | 526 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/btc_miner_wb_regs_if.sv
// Wishbone classic register bus between the UART bridge (master) and the
// miner register block (slave).
//
// Handshake: the master holds wbCycle & wbStrobe with stable address, data,
// wbWe and wbSel. The slave accepts on the first rising edge where none of
// wbAck/wbErr/wbRty is high, and then raises exactly one of them for one
// cycle. The master may drop the strobe right after the accepting edge. A
// pending termination still completes after that.
interface btc_miner_wb_regs_if;
    logic [7:0]  wbAddr;
    logic [3:0]  wbSel;
    logic        wbWe;
    logic [31:0] wbWData;
    logic        wbCycle;
    logic        wbStrobe;
    logic [2:0]  wbCti;
    logic [1:0]  wbBte;
    logic [31:0] wbRData;
    logic        wbAck;
    logic        wbErr;
    logic        wbRty;

    modport master (
        output wbAddr, wbSel, wbWe, wbWData, wbCycle, wbStrobe, wbCti, wbBte,
        input  wbRData, wbAck, wbErr, wbRty
    );

    modport slave (
        input  wbAddr, wbSel, wbWe, wbWData, wbCycle, wbStrobe, wbCti, wbBte,
        output wbRData, wbAck, wbErr, wbRty
    );
endinterface

// File: rtl/btc_miner_wb_regs.sv
// Miner register block: job configuration, start/abort pulses to the hash
// core, and a found-nonce FIFO that the host drains over Wishbone.
module btc_miner_wb_regs #(
    parameter int          FIFO_DEPTH = 4,
    parameter logic [31:0] VERSION    = 32'h0001_0000
) (
    input  logic                      clk,
    input  logic                      arst_n,
    input  logic                      wbRst,
    btc_miner_wb_regs_if.slave        wb,
    output logic [255:0]              coreMidstate,
    output logic [95:0]               coreTail,
    output logic [31:0]               coreNonceStart,
    output logic [31:0]               coreNonceEnd,
    output logic                      coreStart,
    output logic                      coreAbort,
    input  logic                      coreDone,
    input  logic                      coreFoundValid,
    input  logic [31:0]               coreFoundNonce
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [5:0] WORD_CTRL    = 6'd0;
    localparam logic [5:0] WORD_STATUS  = 6'd1;
    localparam logic [5:0] WORD_NSTART  = 6'd2;
    localparam logic [5:0] WORD_NEND    = 6'd3;
    localparam logic [5:0] WORD_FOUND   = 6'd4;
    localparam logic [5:0] WORD_VERSION = 6'd5;
    localparam logic [5:0] WORD_TAIL0   = 6'd16;
    localparam logic [5:0] WORD_TAIL1   = 6'd17;
    localparam logic [5:0] WORD_TAIL2   = 6'd18;

    logic [31:0] midReg [8];
    logic [31:0] tailReg [3];
    logic [31:0] nonceStartReg;
    logic [31:0] nonceEndReg;
    logic        busy;
    logic        done;
    logic        overflow;

    logic [31:0]      fifoMem [FIFO_DEPTH];
    logic [PTR_W:0]   wrPtr;
    logic [PTR_W:0]   rdPtr;
    logic [CNT_W-1:0] fifoCnt;
    logic [31:0]      cntWide;
    logic             fifoEmpty;
    logic             fifoFull;
    logic [2:0]       statusCount;

    logic [5:0]  wordIdx;
    logic        accept;
    logic        isCtrl, isStatus, isFound, isVersion, isMid, isTail, isRw, addrOk;
    logic        doAck, doErr, doRty;
    logic        rwWrite, ctrlWrite, statusWrite;
    logic        startAct, abortAct, doneClr, ovfClr;
    logic        fifoPush, fifoPop, ovfSet;
    logic [31:0] statusWord;
    logic [31:0] readVal;
    logic        unusedBits;

    function automatic logic [31:0] mergeBytes(input logic [31:0] oldVal,
                                               input logic [31:0] newVal,
                                               input logic [3:0]  sel);
        logic [31:0] res;
        res = oldVal;
        for (int i = 0; i < 4; i++) begin
            if (sel[i]) res[8*i +: 8] = newVal[8*i +: 8];
        end
        return res;
    endfunction

    // Burst hints and the byte offset inside a word carry no meaning here.
    assign unusedBits = &{1'b0, wb.wbCti, wb.wbBte, wb.wbAddr[1:0]};

    assign wordIdx = wb.wbAddr[7:2];
    assign accept  = wb.wbCycle & wb.wbStrobe & ~(wb.wbAck | wb.wbErr | wb.wbRty);

    always_comb begin
        isCtrl    = (wordIdx == WORD_CTRL);
        isStatus  = (wordIdx == WORD_STATUS);
        isFound   = (wordIdx == WORD_FOUND);
        isVersion = (wordIdx == WORD_VERSION);
        isMid     = (wordIdx[5:3] == 3'b001);
        isTail    = (wordIdx == WORD_TAIL0) | (wordIdx == WORD_TAIL1) | (wordIdx == WORD_TAIL2);
        isRw      = (wordIdx == WORD_NSTART) | (wordIdx == WORD_NEND) | isMid | isTail;
        addrOk    = isCtrl | isStatus | isFound | isVersion | isRw;
    end

    // Configuration is frozen while a job runs; the bridge is told to retry.
    assign doErr       = accept & ~addrOk;
    assign doRty       = accept & addrOk & wb.wbWe & isRw & busy;
    assign doAck       = accept & addrOk & ~doRty;
    assign rwWrite     = accept & wb.wbWe & isRw & ~busy;
    assign ctrlWrite   = accept & wb.wbWe & isCtrl & wb.wbSel[0];
    assign statusWrite = accept & wb.wbWe & isStatus;

    assign startAct = ctrlWrite & wb.wbWData[0] & ~busy;
    assign abortAct = ctrlWrite & wb.wbWData[1] & busy;
    assign doneClr  = statusWrite & wb.wbSel[0] & wb.wbWData[1];
    assign ovfClr   = statusWrite & wb.wbSel[1] & wb.wbWData[8];

    assign fifoCnt   = wrPtr - rdPtr;
    assign fifoEmpty = (wrPtr == rdPtr);
    assign fifoFull  = (wrPtr[PTR_W] != rdPtr[PTR_W]) &&
                       (wrPtr[PTR_W-1:0] == rdPtr[PTR_W-1:0]);
    assign fifoPop   = accept & ~wb.wbWe & isFound & ~fifoEmpty;
    // A pop on the same edge frees the slot the incoming nonce needs.
    assign fifoPush  = coreFoundValid & (~fifoFull | fifoPop);
    assign ovfSet    = coreFoundValid & fifoFull & ~fifoPop;

    assign cntWide     = 32'(fifoCnt);
    assign statusCount = (cntWide > 32'd7) ? 3'd7 : cntWide[2:0];
    assign statusWord  = {23'd0, overflow, 1'b0, statusCount, 1'b0, ~fifoEmpty, done, busy};

    always_comb begin
        readVal = '0;
        case (wordIdx)
            WORD_STATUS:  readVal = statusWord;
            WORD_NSTART:  readVal = nonceStartReg;
            WORD_NEND:    readVal = nonceEndReg;
            WORD_FOUND:   readVal = fifoEmpty ? 32'hFFFF_FFFF : fifoMem[rdPtr[PTR_W-1:0]];
            WORD_VERSION: readVal = VERSION;
            WORD_TAIL0:   readVal = tailReg[0];
            WORD_TAIL1:   readVal = tailReg[1];
            WORD_TAIL2:   readVal = tailReg[2];
            default: begin
                if (isMid) readVal = midReg[wordIdx[2:0]];
            end
        endcase
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            wb.wbAck   <= 1'b0;
            wb.wbErr   <= 1'b0;
            wb.wbRty   <= 1'b0;
            wb.wbRData <= '0;
            coreStart  <= 1'b0;
            coreAbort  <= 1'b0;
        end else if (wbRst) begin
            wb.wbAck   <= 1'b0;
            wb.wbErr   <= 1'b0;
            wb.wbRty   <= 1'b0;
            wb.wbRData <= '0;
            coreStart  <= 1'b0;
            coreAbort  <= 1'b0;
        end else begin
            wb.wbAck   <= doAck;
            wb.wbErr   <= doErr;
            wb.wbRty   <= doRty;
            wb.wbRData <= (doAck & ~wb.wbWe) ? readVal : '0;
            coreStart  <= startAct;
            coreAbort  <= abortAct;
        end
    end

    // Sticky bits: a set on the same edge as a clear wins.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            busy     <= 1'b0;
            done     <= 1'b0;
            overflow <= 1'b0;
        end else if (wbRst) begin
            busy     <= 1'b0;
            done     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            busy     <= startAct ? 1'b1 : (coreDone ? 1'b0 : busy);
            done     <= coreDone | (done & ~doneClr & ~startAct);
            overflow <= ovfSet | (overflow & ~ovfClr);
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            nonceStartReg <= '0;
            nonceEndReg   <= '1;
            for (int i = 0; i < 8; i++) midReg[i] <= '0;
            for (int i = 0; i < 3; i++) tailReg[i] <= '0;
        end else if (wbRst) begin
            nonceStartReg <= '0;
            nonceEndReg   <= '1;
            for (int i = 0; i < 8; i++) midReg[i] <= '0;
            for (int i = 0; i < 3; i++) tailReg[i] <= '0;
        end else if (rwWrite) begin
            case (wordIdx)
                WORD_NSTART: nonceStartReg <= mergeBytes(nonceStartReg, wb.wbWData, wb.wbSel);
                WORD_NEND:   nonceEndReg   <= mergeBytes(nonceEndReg, wb.wbWData, wb.wbSel);
                WORD_TAIL0:  tailReg[0]    <= mergeBytes(tailReg[0], wb.wbWData, wb.wbSel);
                WORD_TAIL1:  tailReg[1]    <= mergeBytes(tailReg[1], wb.wbWData, wb.wbSel);
                WORD_TAIL2:  tailReg[2]    <= mergeBytes(tailReg[2], wb.wbWData, wb.wbSel);
                default: begin
                    if (isMid) begin
                        midReg[wordIdx[2:0]] <= mergeBytes(midReg[wordIdx[2:0]], wb.wbWData, wb.wbSel);
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            wrPtr <= '0;
            rdPtr <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) fifoMem[i] <= '0;
        end else if (wbRst) begin
            wrPtr <= '0;
            rdPtr <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) fifoMem[i] <= '0;
        end else begin
            if (fifoPush) begin
                fifoMem[wrPtr[PTR_W-1:0]] <= coreFoundNonce;
                wrPtr <= wrPtr + CNT_W'(1);
            end
            if (fifoPop) rdPtr <= rdPtr + CNT_W'(1);
        end
    end

    assign coreMidstate   = {midReg[0], midReg[1], midReg[2], midReg[3],
                             midReg[4], midReg[5], midReg[6], midReg[7]};
    assign coreTail       = {tailReg[0], tailReg[1], tailReg[2]};
    assign coreNonceStart = nonceStartReg;
    assign coreNonceEnd   = nonceEndReg;

endmodule

// File: tb/tb_btc_miner_wb_regs.sv
// Bench for btc_miner_wb_regs: directed scenarios plus randomized traffic
// checked against a register/queue model of the miner register map.
module tb_btc_miner_wb_regs;

    localparam int          DEPTH = 4;
    localparam logic [31:0] VER   = 32'h0001_0000;

    logic         clk = 1'b0;
    logic         arst_n = 1'b0;
    logic         wbRst = 1'b0;
    logic [255:0] coreMidstate;
    logic [95:0]  coreTail;
    logic [31:0]  coreNonceStart, coreNonceEnd;
    logic         coreStart, coreAbort;
    logic         coreDone = 1'b0;
    logic         coreFoundValid = 1'b0;
    logic [31:0]  coreFoundNonce = '0;

    btc_miner_wb_regs_if wbIf();

    btc_miner_wb_regs #(.FIFO_DEPTH(DEPTH), .VERSION(VER)) dut (
        .clk            (clk),
        .arst_n         (arst_n),
        .wbRst          (wbRst),
        .wb             (wbIf.slave),
        .coreMidstate   (coreMidstate),
        .coreTail       (coreTail),
        .coreNonceStart (coreNonceStart),
        .coreNonceEnd   (coreNonceEnd),
        .coreStart      (coreStart),
        .coreAbort      (coreAbort),
        .coreDone       (coreDone),
        .coreFoundValid (coreFoundValid),
        .coreFoundNonce (coreFoundNonce)
    );

    always #5 clk = ~clk;

    int nVec = 0;
    int nErr = 0;

    typedef struct packed {
        logic [31:0] rdata;
        logic [2:0]  term;      // {ack, err, rty}
        logic [2:0]  termAfter;
        logic        startNow, startAfter, abortNow, abortAfter;
    } resp_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic [2:0]  term;
        logic        start, abort;
    } exp_t;

    // Reference model
    logic [31:0] mMid [8];
    logic [31:0] mTail [3];
    logic [31:0] mNs, mNe;
    bit          mBusy, mDone, mOvf;
    logic [31:0] mFifo [$];

    task automatic m_reset();
        for (int i = 0; i < 8; i++) mMid[i] = '0;
        for (int i = 0; i < 3; i++) mTail[i] = '0;
        mNs = '0;
        mNe = 32'hFFFF_FFFF;
        mBusy = 0;
        mDone = 0;
        mOvf = 0;
        mFifo.delete();
    endtask

    function automatic logic [31:0] m_status();
        int cnt = mFifo.size();
        if (cnt > 7) cnt = 7;
        return (32'(mOvf) << 8) | (32'(cnt) << 4) | (32'(mFifo.size() != 0) << 2) |
               (32'(mDone) << 1) | 32'(mBusy);
    endfunction

    function automatic logic [31:0] m_merge(input logic [31:0] o, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] r = o;
        for (int i = 0; i < 4; i++) if (s[i]) r[8*i +: 8] = d[8*i +: 8];
        return r;
    endfunction

    task automatic m_access(input logic [7:0] addr, input logic we, input logic [3:0] sel,
                            input logic [31:0] data, output exp_t e);
        int w = int'(addr[7:2]);
        bit rw = (w == 2) || (w == 3) || (w >= 8 && w <= 18);
        e = '0;
        if (!(rw || w <= 5)) e.term = 3'b010;
        else if (we && rw && mBusy) e.term = 3'b001;
        else begin
            e.term = 3'b100;
            if (!we) begin
                case (w)
                    1: e.rdata = m_status();
                    2: e.rdata = mNs;
                    3: e.rdata = mNe;
                    4: e.rdata = (mFifo.size() != 0) ? mFifo[0] : 32'hFFFF_FFFF;
                    5: e.rdata = VER;
                    default: begin
                        if (w >= 8 && w <= 15) e.rdata = mMid[w-8];
                        else if (w >= 16 && w <= 18) e.rdata = mTail[w-16];
                    end
                endcase
                if (w == 4 && mFifo.size() != 0) void'(mFifo.pop_front());
            end else begin
                if (w == 0 && sel[0]) begin
                    if (data[0] && !mBusy) begin e.start = 1; mBusy = 1; mDone = 0; end
                    else if (data[1] && mBusy) e.abort = 1;
                end
                if (w == 1) begin
                    if (sel[0] && data[1]) mDone = 0;
                    if (sel[1] && data[8]) mOvf = 0;
                end
                if (w == 2) mNs = m_merge(mNs, data, sel);
                if (w == 3) mNe = m_merge(mNe, data, sel);
                if (w >= 8 && w <= 15) mMid[w-8] = m_merge(mMid[w-8], data, sel);
                if (w >= 16 && w <= 18) mTail[w-16] = m_merge(mTail[w-16], data, sel);
            end
        end
    endtask

    task automatic m_push(input logic [31:0] v);
        if (mFifo.size() < DEPTH) mFifo.push_back(v);
        else mOvf = 1;
    endtask

    // Driver tasks
    task automatic wb_xfer(input logic [7:0] addr, input logic we, input logic [3:0] sel,
                           input logic [31:0] data, input bit withPush, input logic [31:0] pushVal,
                           output resp_t r);
        @(negedge clk);
        wbIf.wbAddr = addr;
        wbIf.wbWe = we;
        wbIf.wbSel = sel;
        wbIf.wbWData = data;
        wbIf.wbCti = 3'($urandom_range(0, 7));
        wbIf.wbBte = 2'($urandom_range(0, 3));
        wbIf.wbCycle = 1'b1;
        wbIf.wbStrobe = 1'b1;
        if (withPush) begin coreFoundValid = 1'b1; coreFoundNonce = pushVal; end
        @(posedge clk); #1;
        wbIf.wbCycle = 1'b0;
        wbIf.wbStrobe = 1'b0;
        coreFoundValid = 1'b0;
        r.rdata = wbIf.wbRData;
        r.term = {wbIf.wbAck, wbIf.wbErr, wbIf.wbRty};
        r.startNow = coreStart;
        r.abortNow = coreAbort;
        @(posedge clk); #1;
        r.termAfter = {wbIf.wbAck, wbIf.wbErr, wbIf.wbRty};
        r.startAfter = coreStart;
        r.abortAfter = coreAbort;
    endtask

    task automatic access(input logic [7:0] addr, input logic we, input logic [3:0] sel,
                          input logic [31:0] data, input bit withPush, input logic [31:0] pushVal,
                          output resp_t r, output exp_t e);
        m_access(addr, we, sel, data, e);
        if (withPush) m_push(pushVal);
        wb_xfer(addr, we, sel, data, withPush, pushVal, r);
    endtask

    task automatic push_one(input logic [31:0] v);
        @(negedge clk);
        coreFoundValid = 1'b1;
        coreFoundNonce = v;
        m_push(v);
        @(posedge clk); #1;
        coreFoundValid = 1'b0;
    endtask

    task automatic done_pulse();
        @(negedge clk);
        coreDone = 1'b1;
        mBusy = 0;
        mDone = 1;
        @(posedge clk); #1;
        coreDone = 1'b0;
    endtask

    // Tests
    task automatic test_reset();
        resp_t r;
        exp_t e;
        logic [31:0] want [3];
        logic [7:0]  addrs [3];
        nVec++;
        if ({coreStart, coreAbort, wbIf.wbAck, wbIf.wbErr, wbIf.wbRty} !== 5'b0) begin
            nErr++; $display("FAIL reset_strobes: got %b want 00000",
                             {coreStart, coreAbort, wbIf.wbAck, wbIf.wbErr, wbIf.wbRty});
        end
        nVec++;
        if (coreMidstate !== 256'd0 || coreTail !== 96'd0 || coreNonceStart !== 32'd0) begin
            nErr++; $display("FAIL reset_config: mid %h tail %h nstart %h want 0", coreMidstate, coreTail, coreNonceStart);
        end
        nVec++;
        if (coreNonceEnd !== 32'hFFFF_FFFF) begin
            nErr++; $display("FAIL reset_nonce_end: got %h want ffffffff", coreNonceEnd);
        end
        addrs[0] = 8'h14; want[0] = 32'h0001_0000;
        addrs[1] = 8'h0C; want[1] = 32'hFFFF_FFFF;
        addrs[2] = 8'h04; want[2] = 32'h0;
        for (int i = 0; i < 3; i++) begin
            access(addrs[i], 1'b0, 4'hF, '0, 0, '0, r, e);
            nVec++;
            if (r.term !== 3'b100 || r.termAfter !== 3'b000) begin
                nErr++; $display("FAIL reset_read_term[%0d]: got %b/%b want 100/000", i, r.term, r.termAfter);
            end
            nVec++;
            if (r.rdata !== want[i]) begin
                nErr++; $display("FAIL reset_read_data[%0d]: got %h want %h", i, r.rdata, want[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        wbIf.wbAddr = 8'h14;
        wbIf.wbWe = 1'b0;
        wbIf.wbSel = 4'hF;
        wbIf.wbCycle = 1'b1;
        wbIf.wbStrobe = 1'b1;
        for (int i = 0; i < 6; i++) begin
            logic expAck = (i % 2 == 0);
            logic [31:0] expData = expAck ? VER : 32'd0;
            @(posedge clk); #1;
            if (i == 5) begin wbIf.wbCycle = 1'b0; wbIf.wbStrobe = 1'b0; end
            nVec++;
            if (wbIf.wbAck !== expAck || wbIf.wbRData !== expData) begin
                nErr++; $display("FAIL b2b[%0d]: ack %b data %h want %b %h", i, wbIf.wbAck, wbIf.wbRData, expAck, expData);
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_byte_enable();
        resp_t r;
        exp_t e;
        logic [255:0] expMid;
        logic [95:0]  expTail;
        access(8'h2C, 1'b1, 4'hF, 32'hDEAD_BEEF, 0, '0, r, e);
        access(8'h2C, 1'b1, 4'b0010, 32'h0000_5500, 0, '0, r, e);
        access(8'h2C, 1'b0, 4'hF, '0, 0, '0, r, e);
        nVec++;
        if (r.rdata !== 32'hDEAD_55EF || e.rdata !== 32'hDEAD_55EF) begin
            nErr++; $display("FAIL be_mid3_read: got %h want dead55ef", r.rdata);
        end
        nVec++;
        if (coreMidstate[159:128] !== 32'hDEAD_55EF) begin
            nErr++; $display("FAIL be_mid3_port: got %h want dead55ef", coreMidstate[159:128]);
        end
        for (int k = 0; k < 12; k++) begin
            int rsel = $urandom_range(0, 12);
            logic [7:0] a = 8'((rsel < 2 ? rsel + 2 : rsel + 6) * 4);
            access(a, 1'b1, 4'($urandom_range(0, 15)), $urandom, 0, '0, r, e);
            access(a, 1'b0, 4'hF, '0, 0, '0, r, e);
            nVec++;
            if (r.rdata !== e.rdata || r.term !== e.term) begin
                nErr++; $display("FAIL be_rand[%0d] @%h: got %h/%b want %h/%b", k, a, r.rdata, r.term, e.rdata, e.term);
            end
        end
        for (int i = 0; i < 8; i++) expMid[255-32*i -: 32] = mMid[i];
        for (int i = 0; i < 3; i++) expTail[95-32*i -: 32] = mTail[i];
        nVec++;
        if (coreMidstate !== expMid || coreTail !== expTail || coreNonceStart !== mNs || coreNonceEnd !== mNe) begin
            nErr++; $display("FAIL be_ports: mid %h tail %h ns %h ne %h", coreMidstate, coreTail, coreNonceStart, coreNonceEnd);
        end
    endtask

    task automatic test_start_abort();
        resp_t r;
        exp_t e;
        access(8'h00, 1'b1, 4'h1, 32'h1, 0, '0, r, e);
        nVec++;
        if (r.term !== 3'b100 || r.startNow !== 1'b1 || r.startAfter !== 1'b0 || r.abortNow !== 1'b0) begin
            nErr++; $display("FAIL start_pulse: term %b start %b%b abort %b", r.term, r.startNow, r.startAfter, r.abortNow);
        end
        access(8'h04, 1'b0, 4'hF, '0, 0, '0, r, e);
        nVec++;
        if (r.rdata !== 32'h1) begin
            nErr++; $display("FAIL start_status: got %h want 00000001", r.rdata);
        end
        access(8'h20, 1'b1, 4'hF, 32'h1234_5678, 0, '0, r, e);
        nVec++;
        if (r.term !== 3'b001 || r.termAfter !== 3'b000) begin
            nErr++; $display("FAIL busy_write_rty: got %b/%b want 001/000", r.term, r.termAfter);
        end
        access(8'h20, 1'b0, 4'hF, '0, 0, '0, r, e);
        nVec++;
        if (r.rdata !== e.rdata || r.term !== 3'b100) begin
            nErr++; $display("FAIL busy_write_kept: got %h want %h", r.rdata, e.rdata);
        end
        access(8'h00, 1'b1, 4'h1, 32'h1, 0, '0, r, e);
        nVec++;
        if (r.startNow !== 1'b0 || r.term !== 3'b100) begin
            nErr++; $display("FAIL start_while_busy: start %b term %b want 0 100", r.startNow, r.term);
        end
        access(8'h00, 1'b1, 4'h1, 32'h2, 0, '0, r, e);
        nVec++;
        if (r.abortNow !== 1'b1 || r.abortAfter !== 1'b0) begin
            nErr++; $display("FAIL abort_pulse: got %b%b want 10", r.abortNow, r.abortAfter);
        end
        done_pulse();
        access(8'h04, 1'b0, 4'hF, '0, 0, '0, r, e);
        nVec++;
        if (r.rdata !== 32'h2) begin
            nErr++; $display("FAIL done_status: got %h want 00000002", r.rdata);
        end
        access(8'h00, 1'b1, 4'h1, 32'h2, 0, '0, r, e);
        nVec++;
        if (r.abortNow !== 1'b0 || r.startNow !== 1'b0) begin
            nErr++; $display("FAIL abort_idle: abort %b start %b want 0 0", r.abortNow, r.startNow);
        end
        access(8'h04, 1'b1, 4'hF, 32'h2, 0, '0, r, e);
        access(8'h04, 1'b0, 4'hF, '0, 0, '0, r, e);
        nVec++;
        if (r.rdata !== 32'h0) begin
            nErr++; $display("FAIL done_w1c: got %h want 00000000", r.rdata);
        end
    endtask

    task automatic test_fifo();
        resp_t r;
        exp_t e;
        for (int i = 0; i < 5; i++) push_one(32'h10 + 32'(i));
        access(8'h04, 1'b0, 4'hF, '0, 0, '0, r, e);
        nVec++;
        if (r.rdata !== 32'h144) begin
            nErr++; $display("FAIL fifo_status_full: got %h want 00000144", r.rdata);
        end
        for (int i = 0; i < 5; i++) begin
            logic [31:0] want = (i < 4) ? 32'h10 + 32'(i) : 32'hFFFF_FFFF;
            access(8'h10, 1'b0, 4'hF, '0, 0, '0, r, e);
            nVec++;
            if (r.rdata !== want || e.rdata !== want) begin
                nErr++; $display("FAIL fifo_pop[%0d]: got %h want %h", i, r.rdata, want);
            end
        end
        access(8'h04, 1'b1, 4'h1, 32'h100, 0, '0, r, e);
        access(8'h04, 1'b0, 4'hF, '0, 0, '0, r, e);
        nVec++;
        if (r.rdata !== 32'h100) begin
            nErr++; $display("FAIL ovf_needs_sel1: got %h want 00000100", r.rdata);
        end
        access(8'h04, 1'b1, 4'b0010, 32'h100, 0, '0, r, e);
        access(8'h04, 1'b0, 4'hF, '0, 0, '0, r, e);
        nVec++;
        if (r.rdata !== 32'h0) begin
            nErr++; $display("FAIL ovf_clear: got %h want 00000000", r.rdata);
        end
    endtask

    task automatic test_push_pop_same();
        resp_t r;
        exp_t e;
        logic [31:0] order [4];
        for (int i = 0; i < 4; i++) push_one(32'h20 + 32'(i));
        access(8'h10, 1'b0, 4'hF, '0, 1, 32'h99, r, e);
        nVec++;
        if (r.rdata !== 32'h20) begin
            nErr++; $display("FAIL pp_head: got %h want 00000020", r.rdata);
        end
        access(8'h04, 1'b0, 4'hF, '0, 0, '0, r, e);
        nVec++;
        if (r.rdata !== 32'h44) begin
            nErr++; $display("FAIL pp_status: got %h want 00000044", r.rdata);
        end
        order[0] = 32'h21; order[1] = 32'h22; order[2] = 32'h23; order[3] = 32'h99;
        for (int i = 0; i < 4; i++) begin
            access(8'h10, 1'b0, 4'hF, '0, 0, '0, r, e);
            nVec++;
            if (r.rdata !== order[i]) begin
                nErr++; $display("FAIL pp_order[%0d]: got %h want %h", i, r.rdata, order[i]);
            end
        end
        access(8'h10, 1'b0, 4'hF, '0, 1, 32'h77, r, e);
        nVec++;
        if (r.rdata !== 32'hFFFF_FFFF) begin
            nErr++; $display("FAIL pp_empty_read: got %h want ffffffff", r.rdata);
        end
        access(8'h10, 1'b0, 4'hF, '0, 0, '0, r, e);
        nVec++;
        if (r.rdata !== 32'h77) begin
            nErr++; $display("FAIL pp_empty_push: got %h want 00000077", r.rdata);
        end
        push_one(32'h55);
        access(8'h10, 1'b0, 4'hF, '0, 0, '0, r, e);
        nVec++;
        if (r.rdata !== 32'h55) begin
            nErr++; $display("FAIL push_next_cycle: got %h want 00000055", r.rdata);
        end
    endtask

    task automatic test_errors();
        resp_t r;
        exp_t e;
        logic [7:0] addrs [4];
        addrs[0] = 8'h18; addrs[1] = 8'hFC; addrs[2] = 8'h1C; addrs[3] = 8'h4C;
        for (int i = 0; i < 4; i++) begin
            access(addrs[i], 1'(i % 2), 4'hF, $urandom, 0, '0, r, e);
            nVec++;
            if (r.term !== 3'b010 || r.termAfter !== 3'b000 || r.rdata !== 32'd0) begin
                nErr++; $display("FAIL err_%h: term %b/%b data %h want 010/000 0", addrs[i], r.term, r.termAfter, r.rdata);
            end
        end
    endtask

    task automatic test_random();
        resp_t r;
        exp_t e;
        for (int k = 0; k < 200; k++) begin
            int op = $urandom_range(0, 9);
            logic [7:0] a;
            logic we;
            logic [3:0] sel = 4'($urandom_range(0, 15));
            logic [31:0] d = $urandom;
            bit wp = ($urandom_range(0, 3) == 0);
            if (op == 8) begin push_one($urandom); continue; end
            if (op == 9) begin done_pulse(); continue; end
            if (op <= 3) begin
                we = 1'b0;
                a = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255))
                                                : {6'($urandom_range(0, 18)), 2'($urandom_range(0, 3))};
            end else if (op <= 5) begin
                int rsel = $urandom_range(0, 12);
                we = 1'b1;
                a = 8'((rsel < 2 ? rsel + 2 : rsel + 6) * 4);
            end else begin
                we = 1'b1;
                a = (op == 6) ? 8'h00 : 8'h04;
            end
            access(a, we, sel, d, wp, $urandom, r, e);
            nVec++;
            if (r.term !== e.term || r.rdata !== e.rdata || r.startNow !== e.start || r.abortNow !== e.abort) begin
                nErr++; $display("FAIL rand[%0d] @%h we%b: term %b data %h st %b ab %b want %b %h %b %b",
                                 k, a, we, r.term, r.rdata, r.startNow, r.abortNow, e.term, e.rdata, e.start, e.abort);
            end
        end
    endtask

    task automatic test_sync_reset();
        resp_t r;
        exp_t e;
        done_pulse();
        access(8'h08, 1'b1, 4'hF, 32'h0000_1234, 0, '0, r, e);
        access(8'h00, 1'b1, 4'h1, 32'h1, 0, '0, r, e);
        push_one(32'hABCD);
        @(negedge clk);
        wbRst = 1'b1;
        @(posedge clk); #1;
        wbRst = 1'b0;
        m_reset();
        nVec++;
        if (coreNonceStart !== 32'd0 || coreNonceEnd !== 32'hFFFF_FFFF || coreAbort !== 1'b0) begin
            nErr++; $display("FAIL srst_ports: ns %h ne %h abort %b", coreNonceStart, coreNonceEnd, coreAbort);
        end
        access(8'h04, 1'b0, 4'hF, '0, 0, '0, r, e);
        nVec++;
        if (r.rdata !== 32'd0) begin
            nErr++; $display("FAIL srst_status: got %h want 00000000", r.rdata);
        end
    endtask

    task automatic test_async_reset();
        resp_t r;
        exp_t e;
        access(8'h3C, 1'b1, 4'hF, 32'hA5A5_A5A5, 0, '0, r, e);
        access(8'h40, 1'b1, 4'hF, 32'h5A5A_5A5A, 0, '0, r, e);
        access(8'h00, 1'b1, 4'h1, 32'h1, 0, '0, r, e);
        push_one(32'h4242);
        @(negedge clk); #2;
        arst_n = 1'b0;
        #1;
        nVec++;
        if (coreMidstate !== 256'd0 || coreTail !== 96'd0 || coreStart !== 1'b0 || coreAbort !== 1'b0 ||
            wbIf.wbAck !== 1'b0 || wbIf.wbRData !== 32'd0 || coreNonceEnd !== 32'hFFFF_FFFF) begin
            nErr++; $display("FAIL arst_immediate: mid %h tail %h st %b ab %b ack %b ne %h",
                             coreMidstate, coreTail, coreStart, coreAbort, wbIf.wbAck, coreNonceEnd);
        end
        @(posedge clk); #1;
        nVec++;
        if (coreAbort !== 1'b0) begin
            nErr++; $display("FAIL arst_no_abort: got %b want 0", coreAbort);
        end
        @(negedge clk);
        arst_n = 1'b1;
        m_reset();
        access(8'h04, 1'b0, 4'hF, '0, 0, '0, r, e);
        nVec++;
        if (r.rdata !== 32'd0) begin
            nErr++; $display("FAIL arst_status: got %h want 00000000", r.rdata);
        end
    endtask

    initial begin
        wbIf.wbAddr = '0;
        wbIf.wbSel = '0;
        wbIf.wbWe = 1'b0;
        wbIf.wbWData = '0;
        wbIf.wbCycle = 1'b0;
        wbIf.wbStrobe = 1'b0;
        wbIf.wbCti = '0;
        wbIf.wbBte = '0;
        m_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        arst_n = 1'b1;
        @(negedge clk);
        test_reset();
        test_back_to_back();
        test_byte_enable();
        test_start_abort();
        test_fifo();
        test_push_pop_same();
        test_errors();
        test_random();
        test_sync_reset();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end

endmodule
